// File: rtl/mem_responder_if.sv
// Unified memory port between the multicycle CPU (master) and the memory responder (slave).
// Signal names follow the CPU datapath: Address/WriteData/MemRead/MemWrite in, ReadData/MemReady/MemError/Busy out.
interface mem_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemError;
  logic        Busy;

  modport master (
    output Address, WriteData, MemRead, MemWrite,
    input  ReadData, MemReady, MemError, Busy
  );

  modport slave (
    input  Address, WriteData, MemRead, MemWrite,
    output ReadData, MemReady, MemError, Busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM behind the CPU memory port: accepts one request, waits WAIT_STATES cycles,
// then completes with a one-cycle MemReady pulse (plus MemError when the request was rejected).
module mem_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_count;
  logic [3:0]            w_count_next;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [31:0]           r_wdata;
  logic                  r_is_write;
  logic                  r_err;
  logic [31:0]           r_read_data;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_req_any;
  logic                  w_req_both;
  logic                  w_req_bad;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_is_write;
  logic                  w_err;
  logic                  w_do_read;

  assign w_req_any  = bus.MemRead | bus.MemWrite;
  assign w_req_both = bus.MemRead & bus.MemWrite;
  assign w_req_bad  = w_req_both
                    | (bus.Address[1:0] != 2'b00)
                    | (bus.Address[31:ADDR_WIDTH+2] != '0);
  assign w_accept   = (r_state == S_IDLE) && w_req_any;

  // With zero wait states the request goes straight to RESP, so the read must use the live bus.
  assign w_index    = (r_state == S_IDLE) ? bus.Address[ADDR_WIDTH+1:2] : r_index;
  assign w_is_write = (r_state == S_IDLE) ? bus.MemWrite : r_is_write;
  assign w_err      = (r_state == S_IDLE) ? w_req_bad : r_err;
  assign w_do_read  = (w_state_next == S_RESP) && !w_is_write && !w_err;

  // State register, request latches and the read-data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_count     <= 4'd0;
      r_index     <= '0;
      r_wdata     <= 32'd0;
      r_is_write  <= 1'b0;
      r_err       <= 1'b0;
      r_read_data <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_index    <= bus.Address[ADDR_WIDTH+1:2];
        r_wdata    <= bus.WriteData;
        r_is_write <= bus.MemWrite;
        r_err      <= w_req_bad;
      end
      if (w_do_read) begin
        r_read_data <= r_mem[w_index];
      end
    end
  end

  // RAM contents survive reset; a reset during WAIT leaves r_state in IDLE so no write follows.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_is_write && !r_err) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_req_both) begin
          w_state_next = S_RESP;
          w_count_next = 4'd0;
        end else if (w_req_any) begin
          if (WAIT_STATES == 0) begin
            w_state_next = S_RESP;
            w_count_next = 4'd0;
          end else begin
            w_state_next = S_WAIT;
            w_count_next = C_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_req_any) begin
          w_state_next = S_IDLE;
          w_count_next = 4'd0;
        end else if (r_count <= 4'd1) begin
          w_state_next = S_RESP;
          w_count_next = 4'd0;
        end else begin
          w_count_next = r_count - 4'd1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
        w_count_next = 4'd0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_count_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    bus.ReadData = r_read_data;
    bus.MemReady = (r_state == S_RESP);
    bus.MemError = (r_state == S_RESP) && r_err;
    bus.Busy     = (r_state != S_IDLE);
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of single accesses plus hand-written sequences
// for back-to-back requests, abort during WAIT and reset during an access.
module tb_mem_responder;
  localparam int WS = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_responder_if bus ();

  mem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle, returns in the IDLE cycle after RESP.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic err,
                           output logic [31:0] rdata);
    bit seen;
    seen = 0;
    lat  = 0;
    err  = 1'b0;
    rdata = 32'd0;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Address   = addr;
    bus.WriteData = wdata;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (bus.MemReady === 1'b1) begin
        seen  = 1;
        lat   = c;
        err   = bus.MemError;
        rdata = bus.ReadData;
      end
    end
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL access_timeout addr=%h actual=no_ready required=ready", addr);
    end
    tick();
  endtask

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          first_ready;
    int          second_ready;
    int          ready_count;
    logic        busy_between;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Address   = 32'd0;
    bus.WriteData = 32'd0;

    //          rd    wr    addr         wdata         err   rdata        lat
    vecs[0]  = '{1'b0, 1'b1, 32'h0000000C, 32'hDEADBEEF, 1'b0, 32'h00000000, WS + 1};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000000C, 32'h0,        1'b0, 32'hDEADBEEF, WS + 1};
    vecs[2]  = '{1'b0, 1'b1, 32'h00000010, 32'h12345678, 1'b0, 32'hDEADBEEF, WS + 1};
    vecs[3]  = '{1'b1, 1'b0, 32'h00000010, 32'h0,        1'b0, 32'h12345678, WS + 1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000000D, 32'h0,        1'b1, 32'h12345678, WS + 1};
    vecs[5]  = '{1'b0, 1'b1, 32'h00000000, 32'h11111111, 1'b0, 32'h12345678, WS + 1};
    vecs[6]  = '{1'b0, 1'b1, 32'h00000400, 32'hAAAAAAAA, 1'b1, 32'h12345678, WS + 1};
    vecs[7]  = '{1'b1, 1'b0, 32'h00000000, 32'h0,        1'b0, 32'h11111111, WS + 1};
    vecs[8]  = '{1'b1, 1'b1, 32'h00000004, 32'h0BADBAD0, 1'b1, 32'h11111111, 1};
    vecs[9]  = '{1'b0, 1'b1, 32'h00000004, 32'h55AA55AA, 1'b0, 32'h11111111, WS + 1};
    vecs[10] = '{1'b1, 1'b0, 32'h00000004, 32'h0,        1'b0, 32'h55AA55AA, WS + 1};
    vecs[11] = '{1'b0, 1'b1, 32'h00000002, 32'hFFFFFFFF, 1'b1, 32'h55AA55AA, WS + 1};
    vecs[12] = '{1'b1, 1'b0, 32'h00000000, 32'h0,        1'b0, 32'h11111111, WS + 1};
    vecs[13] = '{1'b0, 1'b1, 32'h000000FC, 32'hCAFEF00D, 1'b0, 32'h11111111, WS + 1};
    vecs[14] = '{1'b1, 1'b0, 32'h000000FC, 32'h0,        1'b0, 32'hCAFEF00D, WS + 1};
    vecs[15] = '{1'b1, 1'b0, 32'h00000100, 32'h0,        1'b1, 32'hCAFEF00D, WS + 1};

    // Reset state
    tick();
    tick();
    check("reset_ReadData", bus.ReadData, 32'd0);
    check("reset_MemReady", {31'd0, bus.MemReady}, 32'd0);
    check("reset_MemError", {31'd0, bus.MemError}, 32'd0);
    check("reset_Busy", {31'd0, bus.Busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, err, rdata);
      $display("txn %0d rd=%0b wr=%0b addr=%h wdata=%h lat=%0d err=%0b rdata=%h",
               i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, err, rdata);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_MemError", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_ReadData", i), rdata, vecs[i].exp_rdata);
    end

    // Back-to-back reads held continuously: 0x00, then 0x04 from the first RESP cycle on.
    first_ready  = -1;
    second_ready = -1;
    busy_between = 1'b1;
    bus.MemRead  = 1'b1;
    bus.Address  = 32'h00000000;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (first_ready >= 0 && c == first_ready + 1) busy_between = bus.Busy;
      if (bus.MemReady === 1'b1) begin
        if (first_ready < 0) begin
          first_ready = c;
          check("b2b_first_ReadData", bus.ReadData, 32'h11111111);
          bus.Address = 32'h00000004;
        end else if (second_ready < 0) begin
          second_ready = c;
          check("b2b_second_ReadData", bus.ReadData, 32'h55AA55AA);
          bus.MemRead = 1'b0;
        end
      end
    end
    bus.MemRead = 1'b0;
    tick();
    $display("txn b2b first_ready=%0d second_ready=%0d", first_ready, second_ready);
    check("b2b_first_latency", first_ready, WS + 1);
    check("b2b_spacing", second_ready - first_ready, WS + 2);
    check("b2b_idle_between", {31'd0, busy_between}, 32'd0);

    // Write abandoned during WAIT: no MemReady, RAM untouched.
    ready_count = 0;
    bus.MemWrite  = 1'b1;
    bus.Address   = 32'h0000000C;
    bus.WriteData = 32'h99999999;
    tick();
    bus.MemWrite  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.MemReady === 1'b1) ready_count++;
    end
    $display("txn abort addr=0000000c ready_pulses=%0d busy=%0b", ready_count, bus.Busy);
    check("abort_no_ready", ready_count, 0);
    check("abort_busy_low", {31'd0, bus.Busy}, 32'd0);
    do_access(1'b1, 1'b0, 32'h0000000C, 32'h0, lat, err, rdata);
    $display("txn %0d rd=1 wr=0 addr=0000000c lat=%0d err=%0b rdata=%h", 16, lat, err, rdata);
    check("abort_ram_kept", rdata, 32'hDEADBEEF);

    // Reset during WAIT of a write to 0x08.
    do_access(1'b0, 1'b1, 32'h00000008, 32'h0BADF00D, lat, err, rdata);
    $display("txn %0d rd=0 wr=1 addr=00000008 lat=%0d err=%0b", 17, lat, err);
    bus.MemWrite  = 1'b1;
    bus.Address   = 32'h00000008;
    bus.WriteData = 32'h77777777;
    tick();
    tick();
    check("midreset_busy_before", {31'd0, bus.Busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_Busy", {31'd0, bus.Busy}, 32'd0);
    check("midreset_MemReady", {31'd0, bus.MemReady}, 32'd0);
    check("midreset_ReadData", bus.ReadData, 32'd0);
    bus.MemWrite = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_access(1'b1, 1'b0, 32'h00000008, 32'h0, lat, err, rdata);
    $display("txn %0d rd=1 wr=0 addr=00000008 lat=%0d err=%0b rdata=%h", 18, lat, err, rdata);
    check("midreset_ram_kept", rdata, 32'h0BADF00D);
    check("midreset_read_latency", lat, WS + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
